// File: rtl/tob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tob_pkg
// Description : Shared types for the top-of-book quote emitter: side encoding,
//               stock index and per-stock quote snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
package tob_pkg;

    localparam int c_DATA_WIDTH = 32;
    localparam int c_NUM_STOCKS = 4;

    typedef enum logic {
        SIDE_BID = 1'b0,
        SIDE_ASK = 1'b1
    } side_e;

    typedef logic [$clog2(c_NUM_STOCKS)-1:0] stock_id_t;

    typedef struct packed {
        logic [c_DATA_WIDTH-1:0] ask;
        logic [c_DATA_WIDTH-1:0] bid;
    } quote_t;

endpackage : tob_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first request
//               found searching upward from i_ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_grant_idx,
    output logic                 o_any_grant
);

    localparam int c_IW = $clog2(N);

    int unsigned     w_idx;
    logic [c_IW-1:0] w_idx_n;
    logic            w_found;

    // Rotating priority search: first set request at or after the pointer wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_found     = 1'b0;
        w_idx       = 0;
        w_idx_n     = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = 32'(i_ptr) + 32'(i);
            if (w_idx >= 32'(N)) begin
                w_idx = w_idx - 32'(N);
            end
            w_idx_n = w_idx[c_IW-1:0];
            if (!w_found && i_req[w_idx_n]) begin
                w_found              = 1'b1;
                o_grant[w_idx_n]     = 1'b1;
                o_grant_idx          = w_idx_n;
            end
        end
        o_any_grant = w_found;
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/top_of_book_emitter.sv
`default_nettype none
// ============================================================================
// Module      : top_of_book_emitter
// Description : Keeps a per-stock bid/ask snapshot from side updates and emits
//               coalesced quotes for two-sided, uncrossed stocks, one per cycle,
//               round-robin across stocks. Counts crossing events.
// Revision    : 1.0 - initial release
// ============================================================================
module top_of_book_emitter
    import tob_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STOCKS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
    input  logic                          i_side,
    input  logic [DATA_WIDTH-1:0]         i_price,
    output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
    output logic [DATA_WIDTH-1:0]         o_best_ask,
    output logic [DATA_WIDTH-1:0]         o_best_bid,
    output logic                          o_data_valid,
    output logic [CNT_WIDTH-1:0]          o_crossed_count
);

    localparam int                c_IW  = $clog2(NUM_STOCKS);
    localparam logic [c_IW:0]     c_NUM = NUM_STOCKS[c_IW:0];

    // Per-stock snapshot
    logic [DATA_WIDTH-1:0] r_ask [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] r_bid [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] r_ask_seen;
    logic [NUM_STOCKS-1:0] r_bid_seen;
    logic [NUM_STOCKS-1:0] r_dirty;
    logic [c_IW-1:0]       r_rr;

    // Registered outputs
    logic [c_IW-1:0]       r_out_id;
    logic [DATA_WIDTH-1:0] r_out_ask;
    logic [DATA_WIDTH-1:0] r_out_bid;
    logic                  r_out_valid;
    logic [CNT_WIDTH-1:0]  r_cross_cnt;

    logic [NUM_STOCKS-1:0] w_elig;
    logic [NUM_STOCKS-1:0] w_gnt_onehot;
    logic [c_IW-1:0]       w_gnt_idx;
    logic                  w_any_grant;

    side_e                 w_side;
    logic                  w_upd_ok;
    logic                  w_price_nz;
    logic [DATA_WIDTH-1:0] w_old_ask, w_old_bid, w_new_ask, w_new_bid;
    logic                  w_old_as, w_old_bs, w_new_as, w_new_bs;
    logic                  w_was_crossed, w_now_crossed, w_cross_evt;

    // A stock is eligible when it has fresh data and a valid, uncrossed book.
    for (genvar k = 0; k < NUM_STOCKS; k++) begin : g_elig
        assign w_elig[k] = r_dirty[k] & r_ask_seen[k] & r_bid_seen[k]
                         & (r_bid[k] < r_ask[k]);
    end

    rr_arbiter #(
        .N (NUM_STOCKS)
    ) u_arb (
        .i_req       (w_elig),
        .i_ptr       (r_rr),
        .o_grant     (w_gnt_onehot),
        .o_grant_idx (w_gnt_idx),
        .o_any_grant (w_any_grant)
    );

    assign w_side     = side_e'(i_side);
    assign w_upd_ok   = i_valid & ({1'b0, i_stock_id} < c_NUM);
    assign w_price_nz = (i_price != '0);

    // Book state of the addressed stock before and after this update, used to
    // detect a transition into a crossed/locked book.
    always_comb begin
        w_old_ask = r_ask[i_stock_id];
        w_old_bid = r_bid[i_stock_id];
        w_old_as  = r_ask_seen[i_stock_id];
        w_old_bs  = r_bid_seen[i_stock_id];
        w_new_ask = w_old_ask;
        w_new_bid = w_old_bid;
        w_new_as  = w_old_as;
        w_new_bs  = w_old_bs;
        if (w_side == SIDE_ASK) begin
            w_new_ask = i_price;
            w_new_as  = w_price_nz;
        end else begin
            w_new_bid = i_price;
            w_new_bs  = w_price_nz;
        end
        w_was_crossed = w_old_as & w_old_bs & (w_old_bid >= w_old_ask);
        w_now_crossed = w_new_as & w_new_bs & (w_new_bid >= w_new_ask);
        w_cross_evt   = w_upd_ok & ~w_was_crossed & w_now_crossed;
    end

    // Snapshot update; a same-cycle update re-sets dirty after the grant clears it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_STOCKS; k++) begin
                r_ask[k] <= '0;
                r_bid[k] <= '0;
            end
            r_ask_seen <= '0;
            r_bid_seen <= '0;
            r_dirty    <= '0;
        end else begin
            r_dirty <= r_dirty & ~w_gnt_onehot;
            if (w_upd_ok) begin
                if (w_side == SIDE_ASK) begin
                    r_ask[i_stock_id]      <= i_price;
                    r_ask_seen[i_stock_id] <= w_price_nz;
                end else begin
                    r_bid[i_stock_id]      <= i_price;
                    r_bid_seen[i_stock_id] <= w_price_nz;
                end
                r_dirty[i_stock_id] <= 1'b1;
            end
        end
    end

    // Quote output register, round-robin pointer and saturating cross counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_id    <= '0;
            r_out_ask   <= '0;
            r_out_bid   <= '0;
            r_out_valid <= 1'b0;
            r_rr        <= '0;
            r_cross_cnt <= '0;
        end else begin
            r_out_valid <= w_any_grant;
            if (w_any_grant) begin
                r_out_id  <= w_gnt_idx;
                r_out_ask <= r_ask[w_gnt_idx];
                r_out_bid <= r_bid[w_gnt_idx];
                r_rr      <= ({1'b0, w_gnt_idx} == c_NUM - 1'b1) ? '0
                                                                 : w_gnt_idx + 1'b1;
            end
            if (w_cross_evt && (r_cross_cnt != '1)) begin
                r_cross_cnt <= r_cross_cnt + 1'b1;
            end
        end
    end

    assign o_stock_id      = r_out_id;
    assign o_best_ask      = r_out_ask;
    assign o_best_bid      = r_out_bid;
    assign o_data_valid    = r_out_valid;
    assign o_crossed_count = r_cross_cnt;

endmodule : top_of_book_emitter
`default_nettype wire

// File: tb/tb_top_of_book_emitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_of_book_emitter
// Description : Scoreboard bench for top_of_book_emitter. Expected quotes are
//               queued as stimulus is driven and compared on each strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_of_book_emitter;
    import tob_pkg::*;

    typedef struct packed {
        stock_id_t id;
        quote_t    q;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [1:0]  i_stock_id = '0;
    logic        i_side = 1'b0;
    logic [31:0] i_price = '0;
    logic [1:0]  o_stock_id;
    logic [31:0] o_best_ask;
    logic [31:0] o_best_bid;
    logic        o_data_valid;
    logic [15:0] o_crossed_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   run_len = 0;
    int   best_run = 0;
    exp_t sb [$];

    top_of_book_emitter #(
        .DATA_WIDTH (32),
        .NUM_STOCKS (4),
        .CNT_WIDTH  (16)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_valid         (i_valid),
        .i_stock_id      (i_stock_id),
        .i_side          (i_side),
        .i_price         (i_price),
        .o_stock_id      (o_stock_id),
        .o_best_ask      (o_best_ask),
        .o_best_bid      (o_best_bid),
        .o_data_valid    (o_data_valid),
        .o_crossed_count (o_crossed_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic upd(input int id, input side_e side, input int price);
        i_valid    = 1'b1;
        i_stock_id = 2'(id);
        i_side     = side;
        i_price    = 32'(price);
        tick();
        i_valid    = 1'b0;
    endtask

    task automatic push(input int id, input int ask, input int bid);
        exp_t e;
        e.id    = stock_id_t'(id);
        e.q.ask = 32'(ask);
        e.q.bid = 32'(bid);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compare every strobe against the head of the scoreboard.
    always @(negedge i_clk) begin
        if (o_data_valid) begin
            run_len++;
            if (run_len > best_run) best_run = run_len;
            if (sb.size() == 0) begin
                chk("unexpected_quote", 64'(o_data_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quote_id",  64'(o_stock_id), 64'(e.id));
                chk("quote_ask", 64'(o_best_ask), 64'(e.q.ask));
                chk("quote_bid", 64'(o_best_bid), 64'(e.q.bid));
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        // Reset
        i_reset = 1'b1;
        idle(2);
        i_reset = 1'b0;
        chk("rst_valid", 64'(o_data_valid), 64'd0);
        chk("rst_id",    64'(o_stock_id), 64'd0);
        chk("rst_ask",   64'(o_best_ask), 64'd0);
        chk("rst_bid",   64'(o_best_bid), 64'd0);
        chk("rst_cnt",   64'(o_crossed_count), 64'd0);

        // 1: two-sided stock 1, 2-edge latency, single pulse
        push(1, 105, 100);
        upd(1, SIDE_BID, 100);
        upd(1, SIDE_ASK, 105);
        chk("t1_valid_early", 64'(o_data_valid), 64'd0);
        tick();
        chk("t1_valid_on", 64'(o_data_valid), 64'd1);
        tick();
        chk("t1_valid_off", 64'(o_data_valid), 64'd0);
        chk("t1_hold_ask", 64'(o_best_ask), 64'd105);

        // 2: locked book blocks, crossing counted once, uncross emits
        upd(2, SIDE_ASK, 50);
        upd(2, SIDE_BID, 50);
        chk("t2_cnt_lock", 64'(o_crossed_count), 64'd1);
        idle(4);
        push(2, 50, 49);
        upd(2, SIDE_BID, 49);
        idle(3);
        chk("t2_cnt_after", 64'(o_crossed_count), 64'd1);

        // 3: bring rr to 2, then stage partially filled stocks and drain 2,3,0,1
        push(1, 105, 101);
        upd(1, SIDE_BID, 101);
        upd(0, SIDE_BID, 10);
        upd(3, SIDE_BID, 20);
        idle(3);
        best_run = 0;
        push(2, 60, 49);
        push(3, 30, 20);
        push(0, 15, 10);
        push(1, 110, 101);
        upd(2, SIDE_ASK, 60);
        upd(3, SIDE_ASK, 30);
        upd(0, SIDE_ASK, 15);
        upd(1, SIDE_ASK, 110);
        idle(4);
        chk("t3_back_to_back", 64'(best_run), 64'd4);

        // 4: update lands on the grant cycle -> old snapshot, then new one
        push(0, 200, 190);
        push(0, 201, 190);
        upd(0, SIDE_BID, 0);
        upd(0, SIDE_ASK, 200);
        upd(0, SIDE_BID, 190);
        upd(0, SIDE_ASK, 201);
        idle(4);
        chk("t4_cnt", 64'(o_crossed_count), 64'd1);

        // 5: three stock-3 bids coalesce into one quote while 1 and 2 are granted
        push(1, 110, 103);
        push(2, 60, 48);
        push(3, 30, 12);
        upd(3, SIDE_ASK, 0);
        upd(3, SIDE_BID, 10);
        upd(1, SIDE_BID, 103);
        upd(3, SIDE_BID, 11);
        upd(2, SIDE_BID, 48);
        upd(3, SIDE_BID, 12);
        upd(3, SIDE_ASK, 30);
        idle(4);

        // 6: reset mid-drain; update during reset is dropped; state cleared
        push(0, 201, 191);
        upd(2, SIDE_ASK, 0);
        upd(0, SIDE_BID, 191);
        upd(1, SIDE_BID, 104);
        i_reset    = 1'b1;
        i_valid    = 1'b1;
        i_stock_id = 2'd3;
        i_side     = SIDE_BID;
        i_price    = 32'd13;
        tick();
        i_valid = 1'b0;
        i_reset = 1'b0;
        chk("t6_valid", 64'(o_data_valid), 64'd0);
        chk("t6_id",    64'(o_stock_id), 64'd0);
        chk("t6_ask",   64'(o_best_ask), 64'd0);
        chk("t6_cnt",   64'(o_crossed_count), 64'd0);
        idle(5);
        upd(3, SIDE_ASK, 40);
        idle(4);
        push(3, 40, 39);
        upd(3, SIDE_BID, 39);
        idle(4);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_top_of_book_emitter
`default_nettype wire
